// File: rtl/vending_input_conditioner.sv
// rtl/vending_input_conditioner.sv - coin/accept/dispense input conditioner
// Synchronizes and debounces three raw levels, then runs a coin acceptance-window FSM.
module vending_input_conditioner #(
  parameter int DB_CYCLES  = 4,
  parameter int WIN_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       raw_m,
  input  logic       raw_a,
  input  logic       raw_d,
  output logic       coin_ok,
  output logic       coin_rej,
  output logic       disp_req,
  output logic       busy,
  output logic [2:0] db_level
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYCLES - 1);
  localparam logic [7:0]    WIN_LOAD = 8'(WIN_CYCLES);

  typedef enum logic {IDLE, WAIT_ACC} state_t;

  // Channel order everywhere: bit 0 = coin sensor, 1 = accepted, 2 = dispense.
  logic [2:0]    raw;
  logic [2:0]    sync1, sync2;
  logic [2:0]    db;
  logic [2:0]    pulse;
  logic [CW-1:0] cnt [3];

  state_t     state, state_n;
  logic [7:0] win_cnt, win_n;
  logic       pending, pend_n;
  logic       ok_n, rej_n, disp_n;
  logic       m_p, a_p, d_p;

  assign raw      = {raw_d, raw_a, raw_m};
  assign m_p      = pulse[0];
  assign a_p      = pulse[1];
  assign d_p      = pulse[2];
  assign db_level = db;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // The rising-edge pulse is registered on the same edge the debounced level flips.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db    <= '0;
      pulse <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        pulse[i] <= 1'b0;
        if (sync2[i] != db[i]) begin
          if (cnt[i] == DB_LAST) begin
            db[i]    <= sync2[i];
            cnt[i]   <= '0;
            pulse[i] <= sync2[i];
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    state_n = state;
    win_n   = win_cnt;
    pend_n  = pending;
    ok_n    = 1'b0;
    rej_n   = 1'b0;
    disp_n  = 1'b0;
    if (ena) begin
      case (state)
        IDLE: begin
          disp_n = d_p | pending;
          pend_n = 1'b0;
          if (m_p) begin
            state_n = WAIT_ACC;
            win_n   = WIN_LOAD;
          end
        end
        WAIT_ACC: begin
          if (d_p) pend_n = 1'b1;
          if (a_p) begin
            ok_n = 1'b1;
            if (m_p) win_n = WIN_LOAD;
            else     state_n = IDLE;
          end else if (m_p) begin
            // A new coin retires the unconfirmed old one and restarts the window.
            rej_n = 1'b1;
            win_n = WIN_LOAD;
          end else if (win_cnt == 8'd0) begin
            rej_n   = 1'b1;
            state_n = IDLE;
          end else begin
            win_n = win_cnt - 8'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      win_cnt  <= '0;
      pending  <= 1'b0;
      coin_ok  <= 1'b0;
      coin_rej <= 1'b0;
      disp_req <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      win_cnt  <= win_n;
      pending  <= pend_n;
      coin_ok  <= ok_n;
      coin_rej <= rej_n;
      disp_req <= disp_n;
      busy     <= (state_n == WAIT_ACC);
    end
  end

endmodule

// File: tb/tb_vending_input_conditioner.sv
// tb/tb_vending_input_conditioner.sv - self-checking bench for vending_input_conditioner
// Segment table, hand-written corner sequences, and a randomized run against a reference model.
module tb_vending_input_conditioner;

  localparam int DB  = 4;
  localparam int WIN = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       raw_m = 1'b0, raw_a = 1'b0, raw_d = 1'b0;
  logic       coin_ok, coin_rej, disp_req, busy;
  logic [2:0] db_level;

  int checks = 0;
  int failures = 0;

  vending_input_conditioner #(.DB_CYCLES(DB), .WIN_CYCLES(WIN)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .raw_m(raw_m), .raw_a(raw_a), .raw_d(raw_d),
    .coin_ok(coin_ok), .coin_rej(coin_rej), .disp_req(disp_req),
    .busy(busy), .db_level(db_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic       m, a, d;
    int         cyc;
    int         e_busy, e_ok, e_rej, e_disp;
    logic [2:0] e_db;
  } seg_t;

  seg_t tbl [21];

  // Reference model: debounced level flips when the last DB synchronized samples all differ
  // from it; coin window tracked as an absolute deadline rather than a down-counter.
  logic [17:0] hist [3];
  logic [2:0]  mdb, mpul;
  logic        mbusy, mpend;
  int          mt, mdead;
  logic [6:0]  mexp;

  task automatic model_reset();
    for (int c = 0; c < 3; c++) hist[c] = '0;
    mdb = '0; mpul = '0; mbusy = 1'b0; mpend = 1'b0; mt = 0; mdead = 0; mexp = '0;
  endtask

  task automatic model_step(input logic [2:0] r);
    logic ok, rej, dr, flip;
    logic [2:0] np;
    mt++;
    ok = 1'b0; rej = 1'b0; dr = 1'b0;
    if (!mbusy) begin
      dr = mpul[2] | mpend;
      mpend = 1'b0;
      if (mpul[0]) begin mbusy = 1'b1; mdead = mt + WIN + 1; end
    end else begin
      if (mpul[2]) mpend = 1'b1;
      if (mpul[1]) begin
        ok = 1'b1;
        if (mpul[0]) mdead = mt + WIN + 1;
        else mbusy = 1'b0;
      end else if (mpul[0]) begin
        rej = 1'b1; mdead = mt + WIN + 1;
      end else if (mt == mdead) begin
        rej = 1'b1; mbusy = 1'b0;
      end
    end
    for (int c = 0; c < 3; c++) begin
      hist[c] = {hist[c][16:0], r[c]};
      flip = 1'b1;
      for (int j = 2; j <= DB + 1; j++) if (hist[c][j] == mdb[c]) flip = 1'b0;
      np[c] = flip & ~mdb[c];
      if (flip) mdb[c] = ~mdb[c];
    end
    mpul = np;
    mexp = {ok, rej, dr, mbusy, mdb};
  endtask

  int nb, nok, nrej, ndisp, gcyc, last_rej, last_disp, nboth;
  int rem [3];
  logic [2:0] rv;

  initial begin
    //          m  a  d  cyc busy ok rej disp db
    tbl[0]  = '{0, 0, 0, 4,  0,   0, 0,  0,   3'b000};
    tbl[1]  = '{1, 0, 0, 10, 4,   0, 0,  0,   3'b001};  // unconfirmed coin
    tbl[2]  = '{0, 0, 0, 20, 5,   0, 1,  0,   3'b000};
    tbl[3]  = '{1, 0, 0, 3,  0,   0, 0,  0,   3'b000};  // glitch
    tbl[4]  = '{0, 0, 0, 10, 0,   0, 0,  0,   3'b000};
    tbl[5]  = '{1, 0, 0, 5,  0,   0, 0,  0,   3'b000};  // coin, accepted in 5th wait cycle
    tbl[6]  = '{1, 1, 0, 1,  0,   0, 0,  0,   3'b001};
    tbl[7]  = '{0, 1, 0, 14, 5,   1, 0,  0,   3'b010};
    tbl[8]  = '{0, 0, 0, 12, 0,   0, 0,  0,   3'b000};
    tbl[9]  = '{1, 0, 0, 1,  0,   0, 0,  0,   3'b000};  // coin, two dispense presses, timeout
    tbl[10] = '{1, 0, 1, 4,  0,   0, 0,  0,   3'b000};
    tbl[11] = '{1, 0, 0, 1,  0,   0, 0,  0,   3'b001};
    tbl[12] = '{0, 0, 0, 3,  3,   0, 0,  0,   3'b101};
    tbl[13] = '{0, 0, 1, 4,  4,   0, 0,  0,   3'b000};
    tbl[14] = '{0, 0, 0, 15, 2,   0, 1,  1,   3'b000};
    tbl[15] = '{0, 0, 1, 1,  0,   0, 0,  0,   3'b000};  // bouncing dispense button
    tbl[16] = '{0, 0, 0, 1,  0,   0, 0,  0,   3'b000};
    tbl[17] = '{0, 0, 1, 1,  0,   0, 0,  0,   3'b000};
    tbl[18] = '{0, 0, 0, 1,  0,   0, 0,  0,   3'b000};
    tbl[19] = '{0, 0, 1, 12, 0,   0, 0,  1,   3'b100};
    tbl[20] = '{0, 0, 0, 12, 0,   0, 0,  0,   3'b000};

    repeat (3) tick();
    check("reset outputs", {coin_ok, coin_rej, disp_req, busy, db_level}, 7'd0);
    rst_n = 1'b1;
    tick();
    check("post-reset idle", {coin_ok, coin_rej, disp_req, busy, db_level}, 7'd0);

    gcyc = 0; last_rej = -100; last_disp = -100; nboth = 0;
    for (int i = 0; i < 21; i++) begin
      raw_m = tbl[i].m; raw_a = tbl[i].a; raw_d = tbl[i].d;
      nb = 0; nok = 0; nrej = 0; ndisp = 0;
      repeat (tbl[i].cyc) begin
        tick();
        gcyc++;
        nb += int'(busy); nok += int'(coin_ok); nrej += int'(coin_rej); ndisp += int'(disp_req);
        if (coin_rej) last_rej = gcyc;
        if (disp_req) last_disp = gcyc;
        if (coin_ok && coin_rej) nboth++;
      end
      check($sformatf("seg%0d busy_cycles", i), nb, tbl[i].e_busy);
      check($sformatf("seg%0d coin_ok", i), nok, tbl[i].e_ok);
      check($sformatf("seg%0d coin_rej", i), nrej, tbl[i].e_rej);
      check($sformatf("seg%0d disp_req", i), ndisp, tbl[i].e_disp);
      check($sformatf("seg%0d db_level", i), db_level, tbl[i].e_db);
      if (i == 14) check("disp one cycle after rej", last_disp - last_rej, 1);
    end
    check("ok and rej together", nboth, 0);

    // ena low: debouncer still follows, coin pulse is discarded
    ena = 1'b0; raw_m = 1'b1;
    repeat (6) tick();
    check("ena0 db follows", db_level, 3'b001);
    raw_m = 1'b0; nb = 0;
    repeat (6) tick();
    nb += int'(busy);
    ena = 1'b1;
    repeat (12) begin tick(); nb += int'(busy) + int'(coin_rej) + int'(coin_ok); end
    check("ena0 coin dropped", nb, 0);

    // reset during the 3rd wait cycle
    raw_m = 1'b1;
    repeat (6) tick();
    raw_m = 1'b0;
    repeat (3) tick();
    check("busy before reset", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("async reset outputs", {coin_ok, coin_rej, disp_req, busy, db_level}, 7'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    nb = 0; nok = 0; nrej = 0;
    repeat (20) begin tick(); nb += int'(busy); nok += int'(coin_ok); nrej += int'(coin_rej); end
    check("post-reset busy", nb, 0);
    check("post-reset coin_ok", nok, 0);
    check("post-reset coin_rej", nrej, 0);

    // randomized run against the model
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    rv = '0;
    for (int c = 0; c < 3; c++) rem[c] = 0;
    nok = 0; nrej = 0; nboth = 0;
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < 3; c++) begin
        if (rem[c] == 0) begin
          rv[c] = ~rv[c];
          rem[c] = int'($urandom_range(1, 10));
        end
        rem[c]--;
      end
      {raw_d, raw_a, raw_m} = rv;
      @(posedge clk);
      model_step(rv);
      @(negedge clk);
      check($sformatf("rand cycle %0d outputs", n),
            {coin_ok, coin_rej, disp_req, busy, db_level}, mexp);
      nok += int'(coin_ok); nrej += int'(coin_rej);
      if (coin_ok && coin_rej) nboth++;
    end
    check("rand ok and rej together", nboth, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
